multicycle_control: RTL and testbench

//  Multicycle MIPS main control FSM; successor to the single-cycle opcode decoder.

---
 rtl/mcc_pkg.sv | 74 +++++++
 rtl/multicycle_control_if.sv | 36 +++
 rtl/mcc_out_decode.sv | 92 +++++++++
 rtl/multicycle_control.sv | 84 ++++++++
 tb/tb_multicycle_control.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mcc_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM: field widths,
// state encoding, opcode/funct constants, mux select codes and the control word.
package mcc_pkg;

    localparam int OPW     = 6;
    localparam int FNW     = 6;
    localparam int ALUOP_W = 2;

    // State numbers are visible on state_o, so the encoding is fixed.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_JAL    = 4'd10,
        S_JR     = 4'd11
    } state_t;

    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_J     = 6'b000010;
    localparam logic [OPW-1:0] OP_JAL   = 6'b000011;
    localparam logic [FNW-1:0] FN_JR    = 6'b001000;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    localparam logic       SRCA_PC = 1'b0;
    localparam logic       SRCA_RS = 1'b1;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    // Everything the datapath needs from the FSM in one cycle.
    typedef struct packed {
        logic               pc_we;
        logic               ir_we;
        logic               mem_rd;
        logic               mem_wr;
        logic               iord;
        logic               reg_we;
        logic [1:0]         reg_dst;
        logic [1:0]         mem_to_reg;
        logic               alu_src_a;
        logic [1:0]         alu_src_b;
        logic [ALUOP_W-1:0] alu_op;
        logic [1:0]         pc_src;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the main FSM (master) and the datapath (slave):
// IR fields and status flags in, mux selects and enables out.
interface multicycle_control_if;
    import mcc_pkg::*;

    logic [OPW-1:0]     opcode;
    logic [FNW-1:0]     funct;
    logic               zero;
    logic               mem_ready;
    logic               pc_we;
    logic               ir_we;
    logic               mem_rd;
    logic               mem_wr;
    logic               iord;
    logic               reg_we;
    logic [1:0]         reg_dst;
    logic [1:0]         mem_to_reg;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         pc_src;
    logic               illegal;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_we, ir_we, mem_rd, mem_wr, iord, reg_we, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, pc_src, illegal
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_we, ir_we, mem_rd, mem_wr, iord, reg_we, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, pc_src, illegal
    );

endinterface

// File: rtl/mcc_out_decode.sv
// Control word decode: pure function of the registered state plus the zero
// flag and mem_ready; reset forces every enable and select to 0.
// MCTRL_JLINK_EN enables the JAL and JR control words.
module mcc_out_decode
    import mcc_pkg::*;
(
    input  state_t state_i,
    input  logic   zero_i,
    input  logic   mem_ready_i,
    input  logic   rst_i,
    output ctrl_t  ctrl_o
);

    // Per-state control word; unlisted fields stay 0 so nothing is don't-care.
    always_comb begin
        ctrl_o = '0;
        if (!rst_i) begin
            case (state_i)
                S_FETCH: begin
                    ctrl_o.mem_rd    = 1'b1;
                    ctrl_o.iord      = 1'b0;
                    ctrl_o.alu_src_a = SRCA_PC;
                    ctrl_o.alu_src_b = SRCB_FOUR;
                    ctrl_o.alu_op    = ALUOP_ADD;
                    ctrl_o.pc_src    = PCSRC_ALU;
                    ctrl_o.ir_we     = mem_ready_i;
                    ctrl_o.pc_we     = mem_ready_i;
                end
                S_DECODE: begin
                    // Branch target computed speculatively into ALUOut.
                    ctrl_o.alu_src_a = SRCA_PC;
                    ctrl_o.alu_src_b = SRCB_IMMSH;
                    ctrl_o.alu_op    = ALUOP_ADD;
                end
                S_MEMADR: begin
                    ctrl_o.alu_src_a = SRCA_RS;
                    ctrl_o.alu_src_b = SRCB_IMM;
                    ctrl_o.alu_op    = ALUOP_ADD;
                end
                S_MEMRD: begin
                    ctrl_o.mem_rd = 1'b1;
                    ctrl_o.iord   = 1'b1;
                end
                S_MEMWB: begin
                    ctrl_o.reg_we     = 1'b1;
                    ctrl_o.reg_dst    = REGDST_RT;
                    ctrl_o.mem_to_reg = WB_MDR;
                end
                S_MEMWR: begin
                    ctrl_o.mem_wr = 1'b1;
                    ctrl_o.iord   = 1'b1;
                end
                S_EXEC: begin
                    ctrl_o.alu_src_a = SRCA_RS;
                    ctrl_o.alu_src_b = SRCB_RT;
                    ctrl_o.alu_op    = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    ctrl_o.reg_we     = 1'b1;
                    ctrl_o.reg_dst    = REGDST_RD;
                    ctrl_o.mem_to_reg = WB_ALUOUT;
                end
                S_BRANCH: begin
                    ctrl_o.alu_src_a = SRCA_RS;
                    ctrl_o.alu_src_b = SRCB_RT;
                    ctrl_o.alu_op    = ALUOP_SUB;
                    ctrl_o.pc_src    = PCSRC_ALUOUT;
                    ctrl_o.pc_we     = zero_i;
                end
                S_JUMP: begin
                    ctrl_o.pc_src = PCSRC_JUMP;
                    ctrl_o.pc_we  = 1'b1;
                end
`ifdef MCTRL_JLINK_EN
                S_JAL: begin
                    ctrl_o.pc_src     = PCSRC_JUMP;
                    ctrl_o.pc_we      = 1'b1;
                    ctrl_o.reg_we     = 1'b1;
                    ctrl_o.reg_dst    = REGDST_RA;
                    ctrl_o.mem_to_reg = WB_PC;
                end
                S_JR: begin
                    ctrl_o.pc_src = PCSRC_RS;
                    ctrl_o.pc_we  = 1'b1;
                end
`endif
                default: ctrl_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM. Sequences fetch/decode/execute/memory/
// writeback with a shared ALU and memory, stalling on mem_ready.
// MCTRL_JLINK_EN adds jal/jr support; without it jal is illegal and jr runs
// as an ordinary R-type.
module multicycle_control
    import mcc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus,
    output logic [3:0]           state_o
);

    state_t state_q, state_d;
    logic   illegal_c;
    ctrl_t  ctrl;

    // State register with synchronous reset back to FETCH.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

`ifndef MCTRL_JLINK_EN
    // funct only matters for jr detection.
    logic unused_funct;
    assign unused_funct = ^bus.funct;
`endif

    // Next-state logic; illegal flags an unknown opcode seen in DECODE.
    always_comb begin
        state_d   = state_q;
        illegal_c = 1'b0;
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
`ifdef MCTRL_JLINK_EN
                    OP_RTYPE:     state_d = (bus.funct == FN_JR) ? S_JR : S_EXEC;
                    OP_JAL:       state_d = S_JAL;
`else
                    OP_RTYPE:     state_d = S_EXEC;
`endif
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    mcc_out_decode u_dec (
        .state_i     (state_q),
        .zero_i      (bus.zero),
        .mem_ready_i (bus.mem_ready),
        .rst_i       (rst),
        .ctrl_o      (ctrl)
    );

    assign bus.pc_we      = ctrl.pc_we;
    assign bus.ir_we      = ctrl.ir_we;
    assign bus.mem_rd     = ctrl.mem_rd;
    assign bus.mem_wr     = ctrl.mem_wr;
    assign bus.iord       = ctrl.iord;
    assign bus.reg_we     = ctrl.reg_we;
    assign bus.reg_dst    = ctrl.reg_dst;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.alu_op     = ctrl.alu_op;
    assign bus.pc_src     = ctrl.pc_src;
    assign bus.illegal    = illegal_c & ~rst;
    assign state_o        = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed reset/lw/sw/beq/R/illegal/jal/jr
// steps followed by random instructions with random memory wait counts,
// checked against per-instruction latency and enable-count expectations.
module tb_multicycle_control;
    import mcc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] state;
    int         n_cmp = 0;
    int         n_bad = 0;

    typedef enum int {K_LW, K_SW, K_R, K_JR, K_BEQ, K_J, K_JAL, K_ILL} kind_t;

    multicycle_control_if bus();

    multicycle_control dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit jlink();
`ifdef MCTRL_JLINK_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Runs one instruction from its first FETCH cycle. n1 = fetch wait cycles,
    // n2 = data-memory wait cycles (lw/sw only), zb = ALU zero flag.
    task automatic run_instr(input kind_t kin, input int n1, input int n2, input bit zb);
        logic [5:0] op, fn;
        kind_t k;
        int lat, m, exp_pc, exp_rd, exp_wr, exp_reg, exp_ill;
        int c_pc, c_ir, c_rd, c_wr, c_reg, c_ill, reg_cyc;
        logic [1:0] wb_dst, wb_m2r, last_pcsrc, last_aluop, exec_aluop;
        fn = 6'($urandom_range(0, 63));
        op = 6'b111111;
        case (kin)
            K_LW:  op = OP_LW;
            K_SW:  op = OP_SW;
            K_R:   begin op = OP_RTYPE; if (fn == FN_JR) fn = 6'b100000; end
            K_JR:  begin op = OP_RTYPE; fn = FN_JR; end
            K_BEQ: op = OP_BEQ;
            K_J:   op = OP_J;
            K_JAL: op = OP_JAL;
            default: begin
                for (int t = 0; t < 50; t++) begin
                    op = 6'($urandom_range(0, 63));
                    if (!(op inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd35, 6'd43})) break;
                    op = 6'b111111;
                end
            end
        endcase
        k = kin;
        if (!jlink() && kin == K_JAL) k = K_ILL;
        if (!jlink() && kin == K_JR)  k = K_R;

        case (k)
            K_LW:                 lat = 5;
            K_SW, K_R:            lat = 4;
            K_JR, K_BEQ, K_J, K_JAL: lat = 3;
            default:              lat = 2;
        endcase
        lat += n1;
        if (k == K_LW || k == K_SW) lat += n2;
        m = n1 + 3;
        exp_pc  = 1 + ((k == K_BEQ) ? int'(zb) : (k == K_J || k == K_JAL || k == K_JR) ? 1 : 0);
        exp_rd  = n1 + 1 + ((k == K_LW) ? n2 + 1 : 0);
        exp_wr  = (k == K_SW) ? n2 + 1 : 0;
        exp_reg = (k == K_LW || k == K_R || k == K_JAL) ? 1 : 0;
        exp_ill = (k == K_ILL) ? 1 : 0;

        c_pc = 0; c_ir = 0; c_rd = 0; c_wr = 0; c_reg = 0; c_ill = 0; reg_cyc = -1;
        wb_dst = 2'b11; wb_m2r = 2'b11; last_pcsrc = 2'b00; last_aluop = 2'b11; exec_aluop = 2'b11;
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            bus.opcode = op;
            bus.funct  = fn;
            bus.zero   = zb;
            if (c < n1)                                            bus.mem_ready = 1'b0;
            else if (c == n1)                                      bus.mem_ready = 1'b1;
            else if ((k == K_LW || k == K_SW) && c >= m && c < m + n2) bus.mem_ready = 1'b0;
            else if ((k == K_LW || k == K_SW) && c == m + n2)      bus.mem_ready = 1'b1;
            else                                                   bus.mem_ready = 1'($urandom_range(0, 1));
            #1;
            if (c == 0) chk("start_fetch", 32'(state), 32'(0));
            if (c == n1 + 1) begin
                chk("decode_state", 32'(state), 32'(1));
                chk("decode_srcb", 32'(bus.alu_src_b), 32'(SRCB_IMMSH));
            end
            c_pc  += int'(bus.pc_we);
            c_ir  += int'(bus.ir_we);
            c_rd  += int'(bus.mem_rd);
            c_wr  += int'(bus.mem_wr);
            c_ill += int'(bus.illegal);
            if (bus.reg_we === 1'b1) begin
                c_reg++; reg_cyc = c; wb_dst = bus.reg_dst; wb_m2r = bus.mem_to_reg;
            end
            if (c == lat - 2) exec_aluop = bus.alu_op;
            if (c == lat - 1) begin last_pcsrc = bus.pc_src; last_aluop = bus.alu_op; end
        end
        chk("pc_we_cnt",   c_pc,  exp_pc);
        chk("ir_we_cnt",   c_ir,  1);
        chk("mem_rd_cnt",  c_rd,  exp_rd);
        chk("mem_wr_cnt",  c_wr,  exp_wr);
        chk("reg_we_cnt",  c_reg, exp_reg);
        chk("illegal_cnt", c_ill, exp_ill);
        if (exp_reg == 1) chk("reg_we_cycle", reg_cyc, lat - 1);
        case (k)
            K_LW:  begin chk("lw_dst", 32'(wb_dst), 32'(REGDST_RT)); chk("lw_m2r", 32'(wb_m2r), 32'(WB_MDR)); end
            K_R:   begin
                chk("r_dst", 32'(wb_dst), 32'(REGDST_RD)); chk("r_m2r", 32'(wb_m2r), 32'(WB_ALUOUT));
                chk("r_aluop", 32'(exec_aluop), 32'(ALUOP_FUNCT));
            end
            K_JAL: begin
                chk("jal_dst", 32'(wb_dst), 32'(REGDST_RA)); chk("jal_m2r", 32'(wb_m2r), 32'(WB_PC));
                chk("jal_pcsrc", 32'(last_pcsrc), 32'(PCSRC_JUMP));
            end
            K_BEQ: begin
                chk("beq_pcsrc", 32'(last_pcsrc), 32'(PCSRC_ALUOUT));
                chk("beq_aluop", 32'(last_aluop), 32'(ALUOP_SUB));
            end
            K_J:   chk("j_pcsrc", 32'(last_pcsrc), 32'(PCSRC_JUMP));
            K_JR:  chk("jr_pcsrc", 32'(last_pcsrc), 32'(PCSRC_RS));
            default: ;
        endcase
    endtask

    initial begin
        rst           = 1'b1;
        bus.opcode    = 6'b111111;
        bus.funct     = '0;
        bus.zero      = 1'b1;
        bus.mem_ready = 1'b1;

        // Reset: everything quiet, state FETCH.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state",   32'(state), 32'(0));
        chk("rst_pc_we",   32'(bus.pc_we), 32'(0));
        chk("rst_ir_we",   32'(bus.ir_we), 32'(0));
        chk("rst_mem_rd",  32'(bus.mem_rd), 32'(0));
        chk("rst_mem_wr",  32'(bus.mem_wr), 32'(0));
        chk("rst_reg_we",  32'(bus.reg_we), 32'(0));
        chk("rst_illegal", 32'(bus.illegal), 32'(0));
        chk("rst_srcb",    32'(bus.alu_src_b), 32'(0));
        rst = 1'b0;
        bus.mem_ready = 1'b0;

        // lw with no waits walks states 0..4, writeback in the fifth cycle.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.opcode = OP_LW; bus.mem_ready = 1'b1;
            #1;
            chk("lw_trace", 32'(state), c);
            chk("lw_reg_we", 32'(bus.reg_we), (c == 4) ? 1 : 0);
        end

        // Directed cases from the feature list.
        run_instr(K_SW, 0, 3, 1'b0);
        run_instr(K_BEQ, 0, 0, 1'b1);
        run_instr(K_BEQ, 0, 0, 1'b0);
        run_instr(K_R, 0, 0, 1'b0);
        run_instr(K_ILL, 0, 0, 1'b0);
        run_instr(K_JAL, 0, 0, 1'b0);
        run_instr(K_JR, 0, 0, 1'b0);

        // Reset in MEMRD with mem_ready high: abandon lw, no writeback.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.opcode = OP_LW; bus.mem_ready = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_state",  32'(state), 32'(3));
        chk("mid_mem_rd", 32'(bus.mem_rd), 32'(0));
        chk("mid_iord",   32'(bus.iord), 32'(0));
        chk("mid_reg_we", 32'(bus.reg_we), 32'(0));
        @(negedge clk);
        #1;
        chk("mid_after_state",  32'(state), 32'(0));
        chk("mid_after_reg_we", 32'(bus.reg_we), 32'(0));
        rst = 1'b0;
        bus.mem_ready = 1'b0;

        // Random instruction mix with random waits.
        for (int i = 0; i < 80; i++) begin
            run_instr(kind_t'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
